fp_norm_round: RTL and testbench
================================

# fp_norm_round

Pipelined normalize-and-round stage that sits directly downstream of the combinational floating-point mantissa/exponent multiplier. It takes the raw product (sign, unbiased-sum exponent, double-width mantissa product, operand special flags) and produces a packed IEEE-style result with zero/underflow/overflow/nan flags. It has two register stages with a valid/ready handshake and sticky exception status.

## Interface
- E, 8, exponent bits
- M, 23, mantissa (fraction) bits
- BITS, 1+M+E, packed result width
- EB, 2**(E-1)-1, exponent bias
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  product word valid
- in_ready  out  1  stage can accept a word
- in_sign  in  1  product sign (X sign ^ Y sign)
- in_exp  in  E+2  signed two's-complement x_exp + y_exp - EB
- in_man  in  2M+2  product of the two {1,fraction} mantissas; value is in [1,4)
- in_zero  in  1  at least one operand is zero
- in_nan  in  1  at least one operand is NaN or infinity
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  BITS  {sign, exponent, fraction}
- zero, underflow, overflow, nan  out  1 each  per-result flags
- clr_sticky  in  1  clears sticky_status
- sticky_status  out  4  {nan, overflow, underflow, zero} OR of all results accepted since clear

## Operation
- Stage 1 (normalize) registers the following values:
  - If in_man[2M+1]=1: frac=in_man[2M:M+1], guard=in_man[M], sticky=|in_man[M-1:0], exp=in_exp+1.
  - Else: frac=in_man[2M-1:M], guard=in_man[M-1], sticky=|in_man[M-2:0], exp=in_exp.
  - sign, in_zero and in_nan pass through.
- Stage 2 (round/pack) rounds per Configuration.
  - If the fraction increment carries out, frac=0 and exp+1.
  - Exponent arithmetic is E+2-bit signed with no wrap; the range -EB..2(2^E-1)-EB+2 fits.
- Classification priority in stage 2 (first match wins):
  1. nan: result={0, all-ones exp, 1, zeros}, nan=1.
  2. zero: result={sign, 0...}, zero=1.
  3. exp >= 2^E-1: result={sign, all-ones, 0}, overflow=1.
  4. exp <= 0: flush to {sign, 0...}, underflow=1, zero=1 (no denormals).
  5. Otherwise: {sign, exp[E-1:0], frac}, all flags 0.
- Flags are registered with result and are valid only when out_valid=1.
- Handshake:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid || s2_load.
  - A transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
- While out_valid && !out_ready, result, flags and out_valid hold unchanged.
- sticky_status ORs in the flags of each output transfer.
  - clr_sticky takes precedence over a same-cycle OR-in: the register goes to 0, and that cycle's flags are lost.

## Timing
- Latency: accepted input appears at out_valid exactly 2 cycles later when out_ready=1.
- Throughput: 1 word/cycle with continuous out_ready.
- in_ready depends combinationally on out_ready. No other combinational in->out path exists.
- Reset, asynchronous and applying immediately mid-operation:
  - s1_valid=0, out_valid=0.
  - result=0, all flags=0, sticky_status=0.
  - in_ready=1.
  - In-flight words are discarded.
- Full pipeline (2 words held, out_ready=0): in_ready=0. When out_ready rises, in_ready=1 in the same cycle.
- Simultaneous accept and emit in a full pipeline: both stages advance with no bubble.

## Configuration
- FPNR_RNE_EN defined: round to nearest, ties to even.
  - Increment frac when guard && (sticky || frac[0]).
- FPNR_RNE_EN undefined: truncate.
  - guard and sticky are ignored and need not be registered.
  - The carry-out path never fires.

## Test plan
- 1.5×1.5: in_exp=127, in_man=0x900000000000, sign 0 -> result=0x40100000 after 2 cycles, all flags 0.
- Tie round: in_exp=127, in_man=0x400000C00000 -> 0x3F800002 with FPNR_RNE_EN, 0x3F800001 without.
- Overflow: in_exp=300, in_man=0x800000000000 -> 0x7F800000, overflow=1. Then in_exp=-10, sign=1 -> 0x80000000, underflow=1, zero=1, sticky_status=4'b0111.
- Specials: in_nan=1 with in_zero=1 -> 0x7FC00000, nan=1, zero=0. in_zero=1 with sign=1 -> 0x80000000, zero=1.
- Backpressure: 3 back-to-back inputs, out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, first result held stable. Release -> outputs arrive in order, none lost.
- Reset asserted mid-stream with 2 words in flight -> out_valid=0 immediately, sticky_status=0, no stale result after release.

Source files
------------

// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalize and round/pack after the FP mantissa multiplier.
// Stage 1 normalizes the [1,4) mantissa product, stage 2 rounds, classifies and packs.
// Optional feature: define FPNR_RNE_EN for round-to-nearest-even; default is truncate.
module fp_norm_round #(
    parameter  int E    = 8,
    parameter  int M    = 23,
    localparam int BITS = 1 + M + E
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [E+1:0]      in_exp,
    input  logic [2*M+1:0]    in_man,
    input  logic              in_zero,
    input  logic              in_nan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BITS-1:0]   result,
    output logic              zero,
    output logic              underflow,
    output logic              overflow,
    output logic              nan,
    input  logic              clr_sticky,
    output logic [3:0]        sticky_status
);

    localparam logic [E+1:0] EXP_MAX = (E+2)'((1 << E) - 1);

    // handshake
    logic w_s2_load;
    logic w_s1_load;
    logic r_s1_valid;

    assign w_s2_load = !out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // stage 1 normalize (combinational part)
    logic           w_hi;
    logic [M-1:0]   w_n_frac;
    logic [E+1:0]   w_n_exp;

    assign w_hi     = in_man[2*M+1];
    assign w_n_frac = w_hi ? in_man[2*M:M+1] : in_man[2*M-1:M];
    assign w_n_exp  = in_exp + {{(E+1){1'b0}}, w_hi};

    logic           r_s1_sign;
    logic [E+1:0]   r_s1_exp;
    logic [M-1:0]   r_s1_frac;
    logic           r_s1_zero;
    logic           r_s1_nan;

`ifdef FPNR_RNE_EN
    logic w_n_guard;
    logic w_n_sticky;
    logic r_s1_guard;
    logic r_s1_sticky;

    assign w_n_guard  = w_hi ? in_man[M] : in_man[M-1];
    assign w_n_sticky = w_hi ? |in_man[M-1:0] : |in_man[M-2:0];

    // stage 1 rounding bits, loaded alongside the normalized word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
        end else if (w_s1_load && in_valid) begin
            r_s1_guard  <= w_n_guard;
            r_s1_sticky <= w_n_sticky;
        end
    end
`else
    // truncation ignores everything below the kept fraction
    logic w_unused;
    assign w_unused = &{1'b0, in_man[M-1:0]};
`endif

    // stage 1 register: valid follows the input whenever the stage loads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_nan   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_n_exp;
                r_s1_frac <= w_n_frac;
                r_s1_zero <= in_zero;
                r_s1_nan  <= in_nan;
            end
        end
    end

    // stage 2 round
    logic [M-1:0]   w_r_frac;
    logic [E+1:0]   w_r_exp;

`ifdef FPNR_RNE_EN
    logic w_inc;
    logic w_cy;
    assign w_inc             = r_s1_guard && (r_s1_sticky || r_s1_frac[0]);
    assign {w_cy, w_r_frac}  = {1'b0, r_s1_frac} + {{M{1'b0}}, w_inc};
    assign w_r_exp           = r_s1_exp + {{(E+1){1'b0}}, w_cy};
`else
    assign w_r_frac = r_s1_frac;
    assign w_r_exp  = r_s1_exp;
`endif

    // exponent range checks on the signed E+2-bit exponent
    logic w_ovf;
    logic w_unf;
    assign w_unf = w_r_exp[E+1] || (w_r_exp == '0);
    assign w_ovf = !w_r_exp[E+1] && (w_r_exp >= EXP_MAX);

    logic [BITS-1:0] w_res;
    logic [3:0]      w_flg;   // {nan, overflow, underflow, zero}

    // classification: nan, zero, overflow, underflow, normal, first match wins
    always_comb begin
        w_res = {r_s1_sign, w_r_exp[E-1:0], w_r_frac};
        w_flg = 4'b0000;
        if (r_s1_nan) begin
            w_res = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            w_flg = 4'b1000;
        end else if (r_s1_zero) begin
            w_res = {r_s1_sign, {(BITS-1){1'b0}}};
            w_flg = 4'b0001;
        end else if (w_ovf) begin
            w_res = {r_s1_sign, {E{1'b1}}, {M{1'b0}}};
            w_flg = 4'b0100;
        end else if (w_unf) begin
            w_res = {r_s1_sign, {(BITS-1){1'b0}}};
            w_flg = 4'b0011;
        end
    end

    // stage 2 register: holds while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            nan       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            zero      <= 1'b0;
        end else if (w_s2_load) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                result                          <= w_res;
                {nan, overflow, underflow, zero} <= w_flg;
            end
        end
    end

    // sticky exception status; clear beats a same-cycle OR-in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_status <= 4'b0000;
        end else if (clr_sticky) begin
            sticky_status <= 4'b0000;
        end else if (out_valid && out_ready) begin
            sticky_status <= sticky_status | {nan, overflow, underflow, zero};
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed test-plan cases plus randomized traffic vs. a value-level model.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_zero, in_nan;
    logic [9:0]  in_exp;
    logic [47:0] in_man;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero, underflow, overflow, nan;
    logic        clr_sticky;
    logic [3:0]  sticky_status;

    int n_cmp = 0;
    int n_err = 0;

    logic [35:0] sb_q[$];
    logic [3:0]  sticky_m;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .in_zero(in_zero), .in_nan(in_nan),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .underflow(underflow),
        .overflow(overflow), .nan(nan),
        .clr_sticky(clr_sticky), .sticky_status(sticky_status)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // value-level model: mantissa value split into kept fraction and remainder
    function automatic logic [35:0] ref_out(input bit s, input int ex, input logic [47:0] man,
                                            input bit z, input bit n);
        int              sh;
        int              e;
        longint unsigned mv, fr;
        logic [7:0]      e8;
        logic [22:0]     f23;
        sh = man[47] ? 24 : 23;
        mv = 64'(man);
        fr = (mv >> sh) & 64'h7F_FFFF;
        e  = ex + (man[47] ? 1 : 0);
`ifdef FPNR_RNE_EN
        begin
            longint unsigned rem, half;
            rem  = mv & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && fr[0])) fr = fr + 1;
            if (fr == 64'h80_0000) begin
                fr = 0;
                e  = e + 1;
            end
        end
`endif
        e8  = e[7:0];
        f23 = fr[22:0];
        if (n)           return {32'h7FC0_0000, 4'b1000};
        if (z)           return {s, 31'd0, 4'b0001};
        if (e >= 255)    return {s, 8'hFF, 23'd0, 4'b0100};
        if (e <= 0)      return {s, 31'd0, 4'b0011};
        return {s, e8, f23, 4'b0000};
    endfunction

    task automatic drive(input bit v, input bit s, input int ex, input logic [47:0] man,
                         input bit z, input bit n);
        in_valid = v;
        in_sign  = s;
        in_exp   = 10'(ex);
        in_man   = man;
        in_zero  = z;
        in_nan   = n;
    endtask

    // one word through an idle pipeline with out_ready=1, checking 2-cycle latency
    task automatic send_one(input string tag, input bit s, input int ex, input logic [47:0] man,
                            input bit z, input bit n, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, s, ex, man, z, n);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0);
        chk({tag, "_lat1"}, out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flg"}, {nan, overflow, underflow, zero}, ef);
        @(negedge clk);
    endtask

    function automatic logic [47:0] rand_man();
        logic [47:0] m;
        m = {$urandom, $urandom};
        if (m[47:46] == 2'b00) m[46] = 1'b1;
        if ($urandom_range(0, 3) == 0) m[21:0] = 22'd0;
        if ($urandom_range(0, 5) == 0) m[22] = 1'b1;
        return m;
    endfunction

    logic [35:0] bp_exp[3];
    logic [47:0] bp_man[3];
    int          bp_got;
    int          ex_r;
    bit          s_r, z_r, n_r;
    logic [47:0] m_r;

    initial begin
        reset      = 1'b1;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0);
        #1;
        chk("rst_ovld", out_valid, 1'b0);
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_res", {result, nan, overflow, underflow, zero}, 36'd0);
        chk("rst_sticky", sticky_status, 4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // test-plan cases
        send_one("mul15", 1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 32'h4010_0000, 4'b0000);
`ifdef FPNR_RNE_EN
        send_one("tie", 1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 32'h3F80_0002, 4'b0000);
`else
        send_one("tie", 1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 32'h3F80_0001, 4'b0000);
`endif
        send_one("ovf", 1'b0, 300, 48'h8000_0000_0000, 1'b0, 1'b0, 32'h7F80_0000, 4'b0100);
        send_one("unf", 1'b1, -10, 48'h8000_0000_0000, 1'b0, 1'b0, 32'h8000_0000, 4'b0011);
        chk("sticky_0111", sticky_status, 4'b0111);
        send_one("nanz", 1'b0, 127, 48'h8000_0000_0000, 1'b1, 1'b1, 32'h7FC0_0000, 4'b1000);
        send_one("negz", 1'b1, 127, 48'h8000_0000_0000, 1'b1, 1'b0, 32'h8000_0000, 4'b0001);
        send_one("maxn", 1'b0, 253, 48'h8000_0000_0000, 1'b0, 1'b0, 32'h7F00_0000, 4'b0000);
        send_one("minn", 1'b1, 1, 48'h4000_0000_0000, 1'b0, 1'b0, 32'h8080_0000, 4'b0000);
        chk("sticky_all", sticky_status, 4'b1111);

        // backpressure: 3 back-to-back words, consumer stalled 4 cycles
        for (int i = 0; i < 3; i++) begin
            bp_man[i] = rand_man();
            bp_exp[i] = ref_out(i[0], 100 + i, bp_man[i], 1'b0, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 100, bp_man[0], 1'b0, 1'b0);
        #1 chk("bp_rdy0", in_ready, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 101, bp_man[1], 1'b0, 1'b0);
        #1 chk("bp_rdy1", in_ready, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 102, bp_man[2], 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_full_rdy", in_ready, 1'b0);
            chk("bp_hold_vld", out_valid, 1'b1);
            chk("bp_hold_res", {result, nan, overflow, underflow, zero}, bp_exp[0]);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", in_ready, 1'b1);
        bp_got = 0;
        for (int c = 0; c < 10 && bp_got < 3; c++) begin
            #1;
            if (out_valid) begin
                chk("bp_order", {result, nan, overflow, underflow, zero}, bp_exp[bp_got]);
                bp_got++;
            end
            @(negedge clk);
            drive(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0);
        end
        chk("bp_count", bp_got, 3);

        // reset mid-stream with two words in flight
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 120, 48'h8000_0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 121, 48'h8000_0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0);
        chk("mid_pre_vld", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_ovld", out_valid, 1'b0);
        chk("mid_sticky", sticky_status, 4'b0000);
        chk("mid_rdy", in_ready, 1'b1);
        chk("mid_res", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid_no_stale", out_valid, 1'b0);
        end

        // randomized traffic against the scoreboard
        sticky_m = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ex_r = int'($urandom_range(0, 560)) - 150;
            s_r  = 1'($urandom);
            z_r  = ($urandom_range(0, 15) == 0);
            n_r  = ($urandom_range(0, 15) == 0);
            m_r  = rand_man();
            drive(($urandom_range(0, 3) != 0), s_r, ex_r, m_r, z_r, n_r);
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 40) == 0);
            #1;
            chk("rnd_sticky", sticky_status, sticky_m);
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rnd_spurious", out_valid, 1'b0);
                end else begin
                    chk("rnd_res", {result, nan, overflow, underflow, zero}, sb_q[0]);
                    if (out_ready) begin
                        if (!clr_sticky) sticky_m = sticky_m | sb_q[0][3:0];
                        void'(sb_q.pop_front());
                    end
                end
            end
            if (clr_sticky) sticky_m = 4'b0000;
            if (in_valid && in_ready) sb_q.push_back(ref_out(s_r, ex_r, m_r, z_r, n_r));
        end

        // drain
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 48'h0, 1'b0, 1'b0);
        clr_sticky = 1'b0;
        out_ready  = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                chk("drain_res", {result, nan, overflow, underflow, zero}, sb_q[0]);
                void'(sb_q.pop_front());
            end
            @(negedge clk);
        end
        chk("drain_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
